rsv_decode_stage: RTL and testbench
===================================

# rsv_decode_stage

Registered, flow-controlled RV32I/RV32E decode stage between fetch and execute. Each accepted instruction word (with its PC) is decoded into register indices, function fields, a one-hot format class, a sign-extended immediate, register-use/write-enable flags and an illegal-instruction flag. The result is presented on a valid/ready output after one cycle. An optional two-entry skid buffer gives full throughput with a registered `in_ready_o`. A flush input discards all held entries.

## Interface
- `PC_W`, 32: width of the PC carried alongside the instruction.
- `RV32E`, 0: 1 marks any *used* register index ≥ 16 illegal.
- `SKID`, 1: 1 selects a two-entry skid buffer with registered `in_ready_o`; 0 selects a single entry with combinational ready.
- `clk_i` in 1: clock. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discard all held entries and the same-cycle input.
- `in_valid_i` in 1: fetch presents an instruction.
- `in_ready_o` out 1: stage accepts this cycle.
- `in_inst_i` in 32: instruction word.
- `in_pc_i` in PC_W: instruction address.
- `out_valid_o` out 1: decoded entry valid.
- `out_ready_i` in 1: execute consumes the entry.
- `out_pc_o` out PC_W: PC of the entry.
- `opcode_o` out 7, `funct3_o` out 3, `funct7_o` out 7: raw instruction fields.
- `rs1_o`, `rs2_o`, `rd_o` out 5 each: register indices.
- `r_type_o`, `i_type_o`, `s_type_o`, `b_type_o`, `u_type_o`, `j_type_o` out 1 each: format class, one-hot or all zero.
- `imm_o` out 32: immediate, sign-extended per format; 0 for R-type and for illegal instructions.
- `rs1_used_o`, `rs2_used_o`, `rd_we_o` out 1 each: operand read flags and register write enable.
- `illegal_o` out 1: instruction is not a legal RV32I/RV32E encoding.

## Operation
- **Opcode classes:**
  - OP (0110011) is R-type.
  - OP-IMM (0010011), LOAD (0000011), JALR (1100111), MISC-MEM (0001111) and SYSTEM (1110011) are I-type.
  - STORE (0100011) is S-type.
  - BRANCH (1100011) is B-type.
  - LUI (0110111) and AUIPC (0010111) are U-type.
  - JAL (1101111) is J-type.
- **Immediates:**
  - I: `{20{i[31]}, i[31:20]}`.
  - S: `{20{i[31]}, i[31:25], i[11:7]}`.
  - B: `{19{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}`.
  - U: `{i[31:12], 12'b0}`.
  - J: `{11{i[31]}, i[31], i[19:12], i[20], i[30:21], 1'b0}`.
- **Illegal when any of:**
  - `opcode[1:0] != 2'b11`, or the opcode is not in the list above.
  - JALR with funct3 ≠ 000.
  - BRANCH with funct3 of 010 or 011.
  - OP with funct7 not 0000000, or funct7 = 0100000 with funct3 not 000/101.
  - RV32E=1 and any used index ≥ 16.
- **On an illegal instruction:** all class bits are 0, `imm_o` is 0, and all `*_used`/`rd_we` flags are 0. The raw fields and PC are still passed through.
- **Use and write flags:**
  - `rs1_used`: R, I (except LUI/AUIPC/JAL), S, B.
  - `rs2_used`: R, S, B.
  - `rd_we`: R, I, U, J, and only when `rd != 0`.
- **Buffer states:**
  - SKID=1: EMPTY, ONE, TWO.
    - EMPTY→ONE on accept.
    - ONE→TWO on accept with no consume.
    - ONE→EMPTY on consume with no accept.
    - TWO→ONE on consume.
    - Accept and consume together in ONE stay in ONE.
  - SKID=0: EMPTY, FULL. `in_ready_o = !out_valid_o || out_ready_i`.
- **Flush:** any state goes to EMPTY on the next cycle. The input presented in the flush cycle is dropped, regardless of `in_ready_o`.
- **Ordering:** entries leave in acceptance order. No entry is duplicated or lost except by flush or reset.

## Timing
- Accept happens on `in_valid_i && in_ready_o`. Consume happens on `out_valid_o && out_ready_i`.
- Latency: an instruction accepted in cycle N is presented in cycle N+1 when the buffer was EMPTY.
- Throughput: 1 per cycle in both modes while `out_ready_i` is held high.
- SKID=1: `in_ready_o` is a flop, equal to (next state ≠ TWO) and not asserted in the cycle after a flush.
- Output payload is held stable while `out_valid_o && !out_ready_i`.
- Reset: state goes to EMPTY, `out_valid_o` = 0 and all payload outputs = 0. `in_ready_o` is 0 during `rst_i` and 1 the cycle after it deasserts.
- Reset asserted mid-operation drops all entries within one cycle.
- `rst_i` takes priority over `flush_i`, which takes priority over accept/consume.

## Structure
- Add to `rsv_pkg`:
  - the complete opcode constant set (LOAD, MISC_MEM, SYSTEM, JALR and the others);
  - a `decode_t` packed struct holding every output payload field;
  - the RV32E index-limit constant.
- Sub-module `rsv_decode_comb`: purely combinational, mapping `{inst, pc}` to `decode_t`, including the illegal check. It is instantiated once at the input.
- `rsv_decode_stage` contains only the buffer registers, the state machine and the handshake logic.

## Test plan
- `ADDI x1,x0,-1` (0xFFF00093), buffer empty, `out_ready_i`=1 → next cycle: `out_valid_o`=1, `i_type_o`=1, `imm_o`=0xFFFFFFFF, `rd_o`=1, `rd_we_o`=1, `rs2_used_o`=0.
- `BEQ x0,x0,-4` (0xFE000EE3) → `b_type_o`=1, `imm_o`=0xFFFFFFFC, `rd_we_o`=0. `LUI` 0x12345037 → `u_type_o`=1, `imm_o`=0x12345000.
- SKID=1, `out_ready_i`=0, three back-to-back inputs → two accepted, then `in_ready_o`=0 and the third is held at the source. Raise `out_ready_i` → all three leave in order, one per cycle, with no gap.
- Two entries held, then `flush_i`=1 together with `in_valid_i`=1 → next cycle `out_valid_o`=0 and nothing from the flush-cycle input ever appears.
- 0x00000000 → `illegal_o`=1, all class bits 0, `imm_o`=0. With RV32E=1, `add x16,x1,x2` (0x00208833) → `illegal_o`=1. With RV32E=0 the same word is a legal R-type with `rd_we_o`=1.
- Assert `rst_i` while in TWO → next cycle `out_valid_o`=0 and all outputs 0. The first input after reset is accepted and appears one cycle later.

Source files
------------

// File: rtl/rsv_pkg.sv
// Shared definitions for the RV32I/RV32E decode stage: opcode map,
// decoded-entry layout and skid-buffer occupancy states.
package rsv_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // RV32E only implements x0..x15
    localparam logic [4:0] RV32E_REG_LIMIT = 5'd16;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               r_type;
        logic               i_type;
        logic               s_type;
        logic               b_type;
        logic               u_type;
        logic               j_type;
        logic signed [31:0] imm;
        logic               rs1_used;
        logic               rs2_used;
        logic               rd_we;
        logic               illegal;
    } decode_t;

endpackage

// File: rtl/rsv_decode_comb.sv
// Combinational RV32I/RV32E instruction decoder: fields, format class,
// immediate, register-use flags and illegal-encoding detection.
module rsv_decode_comb
    import rsv_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic [31:0] inst_i,
    output decode_t     dec_o
);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               cls_r, cls_i, cls_s, cls_b, cls_u, cls_j;
    logic               enc_bad;
    logic               reg_bad;
    logic               illegal;
    logic               use1, use2, writes;
    logic signed [31:0] imm;

    assign opc = inst_i[6:0];
    assign rd  = inst_i[11:7];
    assign f3  = inst_i[14:12];
    assign rs1 = inst_i[19:15];
    assign rs2 = inst_i[24:20];
    assign f7  = inst_i[31:25];

    // Opcodes with bits[1:0] != 2'b11 never match a case item and fall to default
    always_comb begin
        cls_r   = 1'b0;
        cls_i   = 1'b0;
        cls_s   = 1'b0;
        cls_b   = 1'b0;
        cls_u   = 1'b0;
        cls_j   = 1'b0;
        enc_bad = 1'b0;
        case (opc)
            OPC_OP: begin
                cls_r   = 1'b1;
                enc_bad = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_OP_IMM, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: cls_i = 1'b1;
            OPC_JALR: begin
                cls_i   = 1'b1;
                enc_bad = (f3 != 3'b000);
            end
            OPC_STORE: cls_s = 1'b1;
            OPC_BRANCH: begin
                cls_b   = 1'b1;
                enc_bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: cls_u = 1'b1;
            OPC_JAL:            cls_j = 1'b1;
            default:            enc_bad = 1'b1;
        endcase
    end

    assign use1    = cls_r | cls_i | cls_s | cls_b;
    assign use2    = cls_r | cls_s | cls_b;
    assign writes  = cls_r | cls_i | cls_u | cls_j;
    assign reg_bad = RV32E && ((use1   && (rs1 >= RV32E_REG_LIMIT)) ||
                               (use2   && (rs2 >= RV32E_REG_LIMIT)) ||
                               (writes && (rd  >= RV32E_REG_LIMIT)));
    assign illegal = enc_bad | reg_bad;

    always_comb begin
        imm = '0;
        if (cls_i) imm = {{20{inst_i[31]}}, inst_i[31:20]};
        if (cls_s) imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        if (cls_b) imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        if (cls_u) imm = {inst_i[31:12], 12'b0};
        if (cls_j) imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end

    // Raw fields always pass through; everything derived is squashed when illegal
    always_comb begin
        dec_o          = '0;
        dec_o.opcode   = opc;
        dec_o.funct3   = f3;
        dec_o.funct7   = f7;
        dec_o.rs1      = rs1;
        dec_o.rs2      = rs2;
        dec_o.rd       = rd;
        dec_o.illegal  = illegal;
        if (!illegal) begin
            dec_o.r_type   = cls_r;
            dec_o.i_type   = cls_i;
            dec_o.s_type   = cls_s;
            dec_o.b_type   = cls_b;
            dec_o.u_type   = cls_u;
            dec_o.j_type   = cls_j;
            dec_o.imm      = imm;
            dec_o.rs1_used = use1;
            dec_o.rs2_used = use2;
            dec_o.rd_we    = writes && (rd != 5'd0);
        end
    end

endmodule

// File: rtl/rsv_decode_stage.sv
// Registered, flow-controlled decode stage: decodes at the input and holds
// results in a one- or two-entry buffer with valid/ready handshakes.
module rsv_decode_stage
    import rsv_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter bit RV32E = 1'b0,
    parameter bit SKID  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        in_inst_i,
    input  logic [PC_W-1:0]    in_pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [6:0]         opcode_o,
    output logic [2:0]         funct3_o,
    output logic [6:0]         funct7_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [4:0]         rd_o,
    output logic               r_type_o,
    output logic               i_type_o,
    output logic               s_type_o,
    output logic               b_type_o,
    output logic               u_type_o,
    output logic               j_type_o,
    output logic [31:0]        imm_o,
    output logic               rs1_used_o,
    output logic               rs2_used_o,
    output logic               rd_we_o,
    output logic               illegal_o
);

    decode_t         dec_p0;
    decode_t         hd_p1, sk_p1, dec_out;
    logic [PC_W-1:0] hd_pc_p1, sk_pc_p1;
    buf_state_t      state_p1, state_nxt;
    logic            rdy_p1;
    logic            vld_p1;
    logic            acc, cons;
    logic            load_hd, load_sk, shift_sk;

    // Stage p0: decode the incoming word
    rsv_decode_comb #(.RV32E(RV32E)) u_dec (
        .inst_i (in_inst_i),
        .dec_o  (dec_p0)
    );

    assign vld_p1     = (state_p1 != BUF_EMPTY);
    // Reset gates ready directly so it reads 0 while rst_i is high and 1 right after
    assign in_ready_o = !rst_i && (SKID ? rdy_p1 : (!vld_p1 || out_ready_i));
    assign acc        = in_valid_i && in_ready_o && !flush_i;
    assign cons       = vld_p1 && out_ready_i && !flush_i;

    always_comb begin
        state_nxt = state_p1;
        if (flush_i) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state_p1)
                BUF_EMPTY: if (acc) state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (acc && !cons)      state_nxt = BUF_TWO;
                    else if (!acc && cons) state_nxt = BUF_EMPTY;
                end
                BUF_TWO:   if (cons) state_nxt = BUF_ONE;
                default:   state_nxt = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1 <= BUF_EMPTY;
            rdy_p1   <= 1'b1;
        end else begin
            state_p1 <= state_nxt;
            rdy_p1   <= !flush_i && (state_nxt != BUF_TWO);
        end
    end

    assign load_hd  = acc && ((state_p1 == BUF_EMPTY) || ((state_p1 == BUF_ONE) && cons));
    assign load_sk  = acc && (state_p1 == BUF_ONE) && !cons;
    assign shift_sk = cons && (state_p1 == BUF_TWO);

    // Stage p1: head entry drives the outputs, skid entry queues behind it
    always_ff @(posedge clk_i) begin
        if (load_hd) begin
            hd_p1    <= dec_p0;
            hd_pc_p1 <= in_pc_i;
        end else if (shift_sk) begin
            hd_p1    <= sk_p1;
            hd_pc_p1 <= sk_pc_p1;
        end
        if (load_sk) begin
            sk_p1    <= dec_p0;
            sk_pc_p1 <= in_pc_i;
        end
    end

    assign dec_out     = vld_p1 ? hd_p1 : '0;
    assign out_valid_o = vld_p1;
    assign out_pc_o    = vld_p1 ? hd_pc_p1 : '0;
    assign opcode_o    = dec_out.opcode;
    assign funct3_o    = dec_out.funct3;
    assign funct7_o    = dec_out.funct7;
    assign rs1_o       = dec_out.rs1;
    assign rs2_o       = dec_out.rs2;
    assign rd_o        = dec_out.rd;
    assign r_type_o    = dec_out.r_type;
    assign i_type_o    = dec_out.i_type;
    assign s_type_o    = dec_out.s_type;
    assign b_type_o    = dec_out.b_type;
    assign u_type_o    = dec_out.u_type;
    assign j_type_o    = dec_out.j_type;
    assign imm_o       = dec_out.imm;
    assign rs1_used_o  = dec_out.rs1_used;
    assign rs2_used_o  = dec_out.rs2_used;
    assign rd_we_o     = dec_out.rd_we;
    assign illegal_o   = dec_out.illegal;

endmodule

// File: tb/tb_rsv_decode_stage.sv
// Bench for rsv_decode_stage: table of instruction vectors with expected decode,
// scoreboard ordering, and hand sequences for backpressure, flush and reset.
module tb_rsv_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, r_t, i_t, s_t, b_t, u_t, j_t, u1, u2, we, ill;
    logic [31:0] out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    logic        e_in_ready, e_out_valid, e_r, e_i, e_s, e_b, e_u, e_j, e_u1, e_u2, e_we, e_ill;
    logic [31:0] e_out_pc, e_imm;
    logic [6:0]  e_opcode, e_funct7;
    logic [2:0]  e_funct3;
    logic [4:0]  e_rs1, e_rs2, e_rd;

    always #5 clk = ~clk;

    rsv_decode_stage #(.PC_W(32), .RV32E(1'b0), .SKID(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_inst_i(in_inst), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
        .opcode_o(opcode), .funct3_o(funct3), .funct7_o(funct7),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .r_type_o(r_t), .i_type_o(i_t), .s_type_o(s_t), .b_type_o(b_t), .u_type_o(u_t), .j_type_o(j_t),
        .imm_o(imm), .rs1_used_o(u1), .rs2_used_o(u2), .rd_we_o(we), .illegal_o(ill)
    );

    rsv_decode_stage #(.PC_W(32), .RV32E(1'b1), .SKID(1'b1)) dut_e (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(e_in_ready), .in_inst_i(in_inst), .in_pc_i(in_pc),
        .out_valid_o(e_out_valid), .out_ready_i(out_ready), .out_pc_o(e_out_pc),
        .opcode_o(e_opcode), .funct3_o(e_funct3), .funct7_o(e_funct7),
        .rs1_o(e_rs1), .rs2_o(e_rs2), .rd_o(e_rd),
        .r_type_o(e_r), .i_type_o(e_i), .s_type_o(e_s), .b_type_o(e_b), .u_type_o(e_u), .j_type_o(e_j),
        .imm_o(e_imm), .rs1_used_o(e_u1), .rs2_used_o(e_u2), .rd_we_o(e_we), .illegal_o(e_ill)
    );

    // cls = {r,i,s,b,u,j}; flg = {rs1_used, rs2_used, rd_we, illegal}; ill_e = illegal under RV32E
    typedef struct {
        logic [31:0] inst;
        logic [5:0]  cls;
        logic [31:0] imm;
        logic [3:0]  flg;
        logic        ill_e;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
    } sb_t;

    localparam int NV = 17;
    vec_t        tbl[NV];
    sb_t         sbq[$];
    sb_t         mon_it;
    int          checks = 0;
    int          errors = 0;
    int          cur_idx = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [31:0] p0;
    bit          rnd_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare on consume, push on accept
    always @(negedge clk) begin
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h expected no entry", out_pc);
                end else begin
                    mon_it = sbq.pop_front();
                    check($sformatf("pc[%0d]", mon_it.idx), out_pc, mon_it.pc);
                    check($sformatf("fields[%0d]", mon_it.idx),
                          {funct7, rs2, rs1, funct3, rd, opcode}, tbl[mon_it.idx].inst);
                    check($sformatf("class[%0d]", mon_it.idx),
                          {26'b0, r_t, i_t, s_t, b_t, u_t, j_t}, {26'b0, tbl[mon_it.idx].cls});
                    check($sformatf("imm[%0d]", mon_it.idx), imm, tbl[mon_it.idx].imm);
                    check($sformatf("flags[%0d]", mon_it.idx),
                          {28'b0, u1, u2, we, ill}, {28'b0, tbl[mon_it.idx].flg});
                    check($sformatf("ill_rv32e[%0d]", mon_it.idx),
                          {31'b0, e_ill}, {31'b0, tbl[mon_it.idx].ill_e});
                end
            end
            if (in_valid && in_ready) sbq.push_back('{cur_idx, in_pc});
        end
    end

    task automatic put(input int idx);
        bit done;
        int n;
        done     = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_inst  = tbl[idx].inst;
        in_pc    = pc_ctr;
        cur_idx  = idx;
        pc_ctr   = pc_ctr + 32'd4;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 50) begin
                checks++;
                errors++;
                $display("FAIL put_timeout[%0d]: got in_ready 0 expected 1 within 50 cycles", idx);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic hold_entry(input int idx);
        in_valid = 1'b1;
        in_inst  = tbl[idx].inst;
        in_pc    = pc_ctr;
        cur_idx  = idx;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF00093, 6'b010000, 32'hFFFFFFFF, 4'b1010, 1'b0}; // addi x1,x0,-1
        tbl[1]  = '{32'hFE000EE3, 6'b000100, 32'hFFFFFFFC, 4'b1100, 1'b0}; // beq x0,x0,-4
        tbl[2]  = '{32'h12345037, 6'b000010, 32'h12345000, 4'b0000, 1'b0}; // lui x0
        tbl[3]  = '{32'h00000000, 6'b000000, 32'h00000000, 4'b0001, 1'b1};
        tbl[4]  = '{32'h00208833, 6'b100000, 32'h00000000, 4'b1110, 1'b1}; // add x16,x1,x2
        tbl[5]  = '{32'h0020A423, 6'b001000, 32'h00000008, 4'b1100, 1'b0}; // sw x2,8(x1)
        tbl[6]  = '{32'hFF1FF0EF, 6'b000001, 32'hFFFFFFF0, 4'b0010, 1'b0}; // jal x1,-16
        tbl[7]  = '{32'h000090E7, 6'b000000, 32'h00000000, 4'b0001, 1'b1}; // jalr funct3=001
        tbl[8]  = '{32'h00002063, 6'b000000, 32'h00000000, 4'b0001, 1'b1}; // branch funct3=010
        tbl[9]  = '{32'h402081B3, 6'b100000, 32'h00000000, 4'b1110, 1'b0}; // sub x3,x1,x2
        tbl[10] = '{32'h402091B3, 6'b000000, 32'h00000000, 4'b0001, 1'b1}; // f7=0100000 f3=001
        tbl[11] = '{32'h022081B3, 6'b000000, 32'h00000000, 4'b0001, 1'b1}; // mul (not RV32I)
        tbl[12] = '{32'hFFC12283, 6'b010000, 32'hFFFFFFFC, 4'b1010, 1'b0}; // lw x5,-4(x2)
        tbl[13] = '{32'hFFFFFF97, 6'b000010, 32'hFFFFF000, 4'b0010, 1'b1}; // auipc x31
        tbl[14] = '{32'h00000091, 6'b000000, 32'h00000000, 4'b0001, 1'b1}; // opcode[1:0]=01
        tbl[15] = '{32'h00000073, 6'b010000, 32'h00000000, 4'b1000, 1'b0}; // ecall
        tbl[16] = '{32'h0FF0000F, 6'b010000, 32'h000000FF, 4'b1000, 1'b0}; // fence

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; rnd_run = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_imm", imm, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // One-cycle latency from an empty buffer, then the whole table back to back
        @(posedge clk); #1;
        out_ready = 1'b1;
        put(0);
        @(negedge clk);
        check("latency", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) put(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: two accepted, third held at the source, then drain with no gap
        @(posedge clk); #1;
        out_ready = 1'b0;
        p0 = pc_ctr;
        put(5);
        put(6);
        hold_entry(12);
        repeat (2) begin
            @(negedge clk);
            check("skid_full_ready", {31'b0, in_ready}, 32'd0);
            check("hold_pc", out_pc, p0);
            check("hold_imm", imm, 32'h00000008);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("no_gap0", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("no_gap1", {31'b0, out_valid}, 32'd1);
        check("ready_reopen", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no_gap2", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("drained2", {31'b0, out_valid}, 32'd0);

        // Flush with two held entries and a simultaneous input
        @(posedge clk); #1;
        out_ready = 1'b0;
        put(5);
        put(6);
        hold_entry(9);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_empty", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush_no_leak", {31'b0, out_valid}, 32'd0);
        check("ready_after_flush", {31'b0, in_ready}, 32'd1);

        // Reset while two entries are held
        @(posedge clk); #1;
        out_ready = 1'b0;
        put(9);
        put(12);
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_rst", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst2_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_pc", out_pc, 32'd0);
        check("rst2_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'd0);
        check("rst2_imm", imm, 32'd0);
        check("rst2_flags", {20'b0, r_t, i_t, s_t, b_t, u_t, j_t, u1, u2, we, ill}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        put(1);
        @(negedge clk);
        check("lat_after_rst", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // Random backpressure mixed with random vectors
        rnd_run = 1'b1;
        fork
            begin
                for (int k = 0; k < 60; k++) put($urandom_range(0, NV - 1));
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        check("final_valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
